// File: rtl/iq_demod_pkg.sv
// ============================================================================
// iq_demod_pkg - shared types and arithmetic helpers for the IQ demodulator
// Rev 1.0
// ============================================================================
`default_nettype none

package iq_demod_pkg;

  typedef enum logic [1:0] {
    MODE_BYP = 2'd0,
    MODE_POS = 2'd1,
    MODE_NEG = 2'd2
  } mode_t;

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Treats v as a w_in-bit signed value and clips it to a w_out-bit signed range.
  function automatic logic signed [31:0] sat_f(input logic signed [31:0] v,
                                               input int w_in, input int w_out);
    logic signed [31:0] x;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    x  = (v <<< (32 - w_in)) >>> (32 - w_in);
    hi = (32'sd1 <<< (w_out - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w_out - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_quarter_mixer.sv
// ============================================================================
// iq_quarter_mixer - quarter-rate complex LO with frame-aligned mode latch
// Rev 1.0
// ============================================================================
`default_nettype none

module iq_quarter_mixer
  import iq_demod_pkg::*;
#(
  parameter int W_IN  = 5,
  parameter int DECIM = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   adc_rdy,
  input  logic signed [W_IN-1:0] i_in,
  input  logic signed [W_IN-1:0] q_in,
  input  logic [1:0]             mode_sel,
  input  logic                   sync_clr,
  output logic signed [W_IN:0]   rot_i,
  output logic signed [W_IN:0]   rot_q,
  output logic                   rot_valid
);

  localparam int L = log2_f(DECIM);

  logic [L-1:0] r_cnt;
  logic [1:0]   r_phase;
  mode_t        r_mode;

  mode_t               w_mode_req;
  mode_t               w_mode;
  logic [1:0]          w_phase;
  logic signed [W_IN:0] w_i;
  logic signed [W_IN:0] w_q;
  logic signed [W_IN:0] w_rot_i;
  logic signed [W_IN:0] w_rot_q;

  always_comb begin
    case (mode_sel)
      2'd1:    w_mode_req = MODE_POS;
      2'd2:    w_mode_req = MODE_NEG;
      default: w_mode_req = MODE_BYP;
    endcase
    // A new mode is only picked up on the first sample of a frame, and restarts the LO.
    w_mode  = (r_cnt == '0) ? w_mode_req : r_mode;
    w_phase = (w_mode != r_mode) ? 2'd0 : r_phase;
    w_i     = {i_in[W_IN-1], i_in};
    w_q     = {q_in[W_IN-1], q_in};
    w_rot_i = w_i;
    w_rot_q = w_q;
    if (w_mode != MODE_BYP) begin
      case (w_phase)
        2'd1: begin
          w_rot_i = (w_mode == MODE_POS) ? w_q  : -w_q;
          w_rot_q = (w_mode == MODE_POS) ? -w_i : w_i;
        end
        2'd2: begin
          w_rot_i = -w_i;
          w_rot_q = -w_q;
        end
        2'd3: begin
          w_rot_i = (w_mode == MODE_POS) ? -w_q : w_q;
          w_rot_q = (w_mode == MODE_POS) ? w_i  : -w_i;
        end
        default: begin
          w_rot_i = w_i;
          w_rot_q = w_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_phase   <= 2'd0;
      r_mode    <= MODE_BYP;
      rot_i     <= '0;
      rot_q     <= '0;
      rot_valid <= 1'b0;
    end else if (sync_clr) begin
      r_cnt     <= '0;
      r_phase   <= 2'd0;
      rot_valid <= 1'b0;
    end else begin
      rot_valid <= adc_rdy;
      if (adc_rdy) begin
        r_mode  <= w_mode;
        r_phase <= w_phase + 2'd1;
        r_cnt   <= r_cnt + 1'b1;
        rot_i   <= w_rot_i;
        rot_q   <= w_rot_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iq_demod_param.sv
// ============================================================================
// iq_demod_param - mixer, boxcar decimator, rounding, gain and saturation
// Rev 1.0
// ============================================================================
`default_nettype none

module iq_demod_param
  import iq_demod_pkg::*;
#(
  parameter int W_IN     = 5,
  parameter int W_OUT    = 5,
  parameter int DECIM    = 4,
  parameter int GAIN_SHL = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ADC_rdy_i,
  input  logic signed [W_IN-1:0]  I_IF,
  input  logic signed [W_IN-1:0]  Q_IF,
  input  logic [1:0]              mode_i,
  input  logic                    sync_clr_i,
  output logic                    demod_iq_valid,
  output logic signed [W_OUT-1:0] I_BB,
  output logic signed [W_OUT-1:0] Q_BB,
  output logic                    sat_o
);

  localparam int L  = log2_f(DECIM);
  localparam int WA = W_IN + 1 + L;
  localparam int WR = WA + 1;
  localparam int WG = WR + 3;
  localparam logic signed [WR-1:0] c_half = WR'(2 ** (L - 1));

  logic signed [W_IN:0] w_rot_i;
  logic signed [W_IN:0] w_rot_q;
  logic                 w_rot_valid;

  iq_quarter_mixer #(
    .W_IN  (W_IN),
    .DECIM (DECIM)
  ) u_mixer (
    .clk       (clk),
    .resetn    (resetn),
    .adc_rdy   (ADC_rdy_i),
    .i_in      (I_IF),
    .q_in      (Q_IF),
    .mode_sel  (mode_i),
    .sync_clr  (sync_clr_i),
    .rot_i     (w_rot_i),
    .rot_q     (w_rot_q),
    .rot_valid (w_rot_valid)
  );

  function automatic logic signed [WG-1:0] scale_f(input logic signed [WA-1:0] s);
    logic signed [WR-1:0] t;
    t = (WR'(s) + c_half) >>> L;
    return WG'(t) <<< GAIN_SHL;
  endfunction

  logic [L-1:0]         r_cnt;
  logic signed [WA-1:0] r_acc_i;
  logic signed [WA-1:0] r_acc_q;
  logic signed [WA-1:0] r_sum_i;
  logic signed [WA-1:0] r_sum_q;
  logic                 r_sum_valid;

  logic signed [WA-1:0] w_add_i;
  logic signed [WA-1:0] w_add_q;
  logic signed [WG-1:0] w_g_i;
  logic signed [WG-1:0] w_g_q;
  logic signed [31:0]   w_s_i;
  logic signed [31:0]   w_s_q;
  logic                 w_clip;

  always_comb begin
    w_add_i = r_acc_i + WA'(w_rot_i);
    w_add_q = r_acc_q + WA'(w_rot_q);
    w_g_i   = scale_f(r_sum_i);
    w_g_q   = scale_f(r_sum_q);
    w_s_i   = sat_f(32'(w_g_i), WG, W_OUT);
    w_s_q   = sat_f(32'(w_g_q), WG, W_OUT);
    w_clip  = (w_s_i != 32'(w_g_i)) || (w_s_q != 32'(w_g_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_sum_i     <= '0;
      r_sum_q     <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (sync_clr_i) begin
        r_cnt   <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (w_rot_valid) begin
        if (&r_cnt) begin
          r_sum_i     <= w_add_i;
          r_sum_q     <= w_add_q;
          r_sum_valid <= 1'b1;
          r_acc_i     <= '0;
          r_acc_q     <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc_i <= w_add_i;
          r_acc_q <= w_add_q;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      demod_iq_valid <= 1'b0;
      I_BB           <= '0;
      Q_BB           <= '0;
      sat_o          <= 1'b0;
    end else begin
      demod_iq_valid <= r_sum_valid;
      if (r_sum_valid) begin
        I_BB  <= W_OUT'(w_s_i);
        Q_BB  <= W_OUT'(w_s_q);
        sat_o <= sat_o | w_clip;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iq_demod_param.sv
// ============================================================================
// tb_iq_demod_param - directed checks of iq_demod_param (GAIN_SHL 0 and 1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iq_demod_param;

  logic              clk;
  logic              resetn;
  logic              adc_rdy;
  logic signed [4:0] i_if;
  logic signed [4:0] q_if;
  logic [1:0]        mode;
  logic              sync_clr;

  logic              v0, s0, v1, s1;
  logic signed [4:0] ib0, qb0, ib1, qb1;

  int checks;
  int failures;

  iq_demod_param #(.W_IN(5), .W_OUT(5), .DECIM(4), .GAIN_SHL(0)) dut0 (
    .clk (clk), .resetn (resetn), .ADC_rdy_i (adc_rdy), .I_IF (i_if), .Q_IF (q_if),
    .mode_i (mode), .sync_clr_i (sync_clr), .demod_iq_valid (v0),
    .I_BB (ib0), .Q_BB (qb0), .sat_o (s0)
  );

  iq_demod_param #(.W_IN(5), .W_OUT(5), .DECIM(4), .GAIN_SHL(1)) dut1 (
    .clk (clk), .resetn (resetn), .ADC_rdy_i (adc_rdy), .I_IF (i_if), .Q_IF (q_if),
    .mode_i (mode), .sync_clr_i (sync_clr), .demod_iq_valid (v1),
    .I_BB (ib1), .Q_BB (qb1), .sat_o (s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Four back-to-back samples with constant Q; leaves the bench on the output-pulse cycle.
  task automatic frame(input int a, input int b, input int c, input int d, input int qv);
    int arr[4];
    arr = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      adc_rdy = 1'b1;
      i_if    = 5'(arr[k]);
      q_if    = 5'(qv);
      tick();
      chk("no_early_valid", 32'(v0), 0);
    end
    adc_rdy = 1'b0;
    tick();
    chk("no_early_valid", 32'(v0), 0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    adc_rdy  = 1'b0;
    i_if     = '0;
    q_if     = '0;
    mode     = 2'd0;
    sync_clr = 1'b0;

    tick();
    tick();
    chk("rst_valid", 32'(v0), 0);
    chk("rst_ibb", ib0, 0);
    chk("rst_qbb", qb0, 0);
    chk("rst_sat", 32'(s0), 0);
    resetn = 1'b1;
    tick();

    // Bypass, constant (3,-2), one strobe every 5th cycle
    for (int k = 0; k < 4; k++) begin
      adc_rdy = 1'b1;
      i_if    = 5'sd3;
      q_if    = -5'sd2;
      tick();
      adc_rdy = 1'b0;
      if (k < 3) begin
        for (int j = 0; j < 4; j++) begin
          tick();
          chk("byp_idle_valid", 32'(v0), 0);
        end
      end
    end
    tick();
    chk("byp_lat1_valid", 32'(v0), 0);
    tick();
    chk("byp_valid", 32'(v0), 1);
    chk("byp_ibb", ib0, 3);
    chk("byp_qbb", qb0, -2);
    chk("byp_sat", 32'(s0), 0);
    chk("byp_gain_ibb", ib1, 6);
    chk("byp_gain_qbb", qb1, -4);
    chk("byp_gain_sat", 32'(s1), 0);
    tick();
    chk("byp_pulse_end", 32'(v0), 0);
    chk("byp_hold_ibb", ib0, 3);

    // +fs/4 mode, tone at +fs/4, full-rate strobes over three frames
    mode = 2'd1;
    for (int t = 0; t < 14; t++) begin
      logic exp_v;
      if (t < 12) begin
        adc_rdy = 1'b1;
        case (t % 4)
          0: begin i_if = 5'sd10;  q_if = 5'sd0;   end
          1: begin i_if = 5'sd0;   q_if = 5'sd10;  end
          2: begin i_if = -5'sd10; q_if = 5'sd0;   end
          default: begin i_if = 5'sd0; q_if = -5'sd10; end
        endcase
      end else begin
        adc_rdy = 1'b0;
      end
      tick();
      exp_v = (t >= 5) && (((t - 5) % 4) == 0);
      chk("pos_valid", 32'(v0), 32'(exp_v));
      if (exp_v) begin
        chk("pos_ibb", ib0, 10);
        chk("pos_qbb", qb0, 0);
      end
    end
    mode = 2'd0;

    // Round-half-up behaviour in bypass
    frame(1, 1, 1, 0, 0);
    chk("rnd_a_valid", 32'(v0), 1);
    chk("rnd_a_ibb", ib0, 1);
    frame(-1, -1, 0, 0, 0);
    chk("rnd_b_valid", 32'(v0), 1);
    chk("rnd_b_ibb", ib0, 0);
    frame(-2, -2, -2, -1, 0);
    chk("rnd_c_valid", 32'(v0), 1);
    chk("rnd_c_ibb", ib0, -2);
    tick();

    // sync clear after 2 samples, then clear colliding with a strobe
    adc_rdy = 1'b1; i_if = 5'sd15; q_if = 5'sd15;
    tick();
    tick();
    adc_rdy = 1'b0; sync_clr = 1'b1;
    tick();
    chk("clr_no_valid", 32'(v0), 0);
    sync_clr = 1'b0; adc_rdy = 1'b1;
    tick();
    chk("clr_no_valid", 32'(v0), 0);
    sync_clr = 1'b1;
    tick();
    chk("clr_no_valid", 32'(v0), 0);
    sync_clr = 1'b0; adc_rdy = 1'b0;
    tick();
    chk("clr_no_valid", 32'(v0), 0);
    tick();
    chk("clr_no_valid", 32'(v0), 0);
    frame(5, 5, 5, 5, -3);
    chk("clr_valid", 32'(v0), 1);
    chk("clr_ibb", ib0, 5);
    chk("clr_qbb", qb0, -3);
    tick();

    // Asynchronous reset mid-frame
    adc_rdy = 1'b1; i_if = 5'sd9; q_if = 5'sd9;
    tick();
    tick();
    adc_rdy = 1'b0;
    resetn  = 1'b0;
    #1;
    chk("amid_valid", 32'(v0), 0);
    chk("amid_ibb", ib0, 0);
    chk("amid_qbb", qb0, 0);
    chk("amid_gain_ibb", ib1, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Mode change to -fs/4 mid-frame must wait for the next frame
    mode = 2'd0;
    adc_rdy = 1'b1; i_if = 5'sd4; q_if = 5'sd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) mode = 2'd2;
      tick();
      chk("mchg_no_early", 32'(v0), 0);
    end
    adc_rdy = 1'b0;
    tick();
    chk("mchg_lat1", 32'(v0), 0);
    tick();
    chk("mchg_valid", 32'(v0), 1);
    chk("mchg_ibb", ib0, 4);
    chk("mchg_qbb", qb0, 0);
    for (int k = 0; k < 4; k++) begin
      adc_rdy = 1'b1;
      case (k)
        0: begin i_if = 5'sd6;  q_if = 5'sd0;  end
        1: begin i_if = 5'sd0;  q_if = -5'sd6; end
        2: begin i_if = -5'sd6; q_if = 5'sd0;  end
        default: begin i_if = 5'sd0; q_if = 5'sd6; end
      endcase
      tick();
    end
    adc_rdy = 1'b0;
    tick();
    tick();
    chk("neg_valid", 32'(v0), 1);
    chk("neg_ibb", ib0, 6);
    chk("neg_qbb", qb0, 0);
    chk("neg_gain_sat", 32'(s1), 0);
    tick();

    // Gain shift with saturation, sticky flag
    mode = 2'd0;
    frame(12, 12, 12, 12, -16);
    chk("gain_valid", 32'(v1), 1);
    chk("gain_ibb", ib1, 15);
    chk("gain_qbb", qb1, -16);
    chk("gain_sat", 32'(s1), 1);
    chk("nogain_ibb", ib0, 12);
    chk("nogain_qbb", qb0, -16);
    chk("nogain_sat", 32'(s0), 0);
    frame(0, 0, 0, 0, 0);
    chk("sticky_ibb", ib1, 0);
    chk("sticky_sat", 32'(s1), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iq_demod_param.md
Name: iq_demod_param

Overview:
- Parametrised successor to the fixed 5-bit IQ demodulator in the Zigbee receive chain.
- Sits between the ADC sample interface and the CORDIC; consumes I_IF/Q_IF samples qualified by ADC_rdy_i and produces decimated baseband I_BB/Q_BB with a one-cycle demod_iq_valid strobe.
- Adds a selectable quarter-rate complex LO (bypass / +fs/4 / -fs/4), a power-of-2 boxcar decimator with rounding, a post-average gain shift, saturation with a sticky flag, and a synchronous frame clear.

Parameters:
- W_IN, 5, signed width of I_IF/Q_IF.
- W_OUT, 5, signed width of I_BB/Q_BB.
- DECIM, 4, decimation ratio; power of 2, at least 2.
- GAIN_SHL, 0, left shift applied after averaging; range 0..3.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- ADC_rdy_i  in  1  sample strobe from the ADC; may be high on consecutive cycles.
- I_IF  in  W_IN  signed in-phase input sample.
- Q_IF  in  W_IN  signed quadrature input sample.
- mode_i  in  2  LO mode: 0 = bypass, 1 = +fs/4, 2 = -fs/4, 3 = reserved (treated as bypass).
- sync_clr_i  in  1  synchronous clear of phase, frame counter and accumulators.
- demod_iq_valid  out  1  one-cycle pulse marking a new output; goes to the CORDIC.
- I_BB  out  W_OUT  signed baseband in-phase output.
- Q_BB  out  W_OUT  signed baseband quadrature output.
- sat_o  out  1  sticky saturation flag.

Behaviour:
- Reset: asynchronous, active-low. All state is cleared. demod_iq_valid=0, I_BB=0, Q_BB=0, sat_o=0, phase=0, cnt=0, acc=0, latched mode=bypass.
- Interface: one clock; reset is asynchronous and active-low (ports clk, resetn).
- Stage 1, mixer, registered:
  - On each clock edge where ADC_rdy_i=1, sign-extend I/Q to W_IN+1 bits so that negating the minimum value cannot overflow.
  - Rotate by phase n in 0..3. n increments mod 4 per accepted sample.
  - +fs/4 mode: n0 (I,Q), n1 (Q,-I), n2 (-I,-Q), n3 (-Q,I).
  - -fs/4 mode: n0 (I,Q), n1 (-Q,I), n2 (-I,-Q), n3 (Q,-I).
  - Bypass mode: (I,Q) for every n.
  - A rot_valid flag is registered alongside the rotated sample.
- Mode latching: mode_i is latched only when a sample is accepted with cnt==0. Phase resets to 0 whenever the latched mode changes value, so a mode change takes effect only on a frame boundary.
- Stage 2, decimator:
  - Accumulator width is W_IN+1+log2(DECIM), separate for I and Q.
  - On each rot_valid, when cnt<DECIM-1: acc += s and cnt++.
  - When cnt==DECIM-1: sum = acc+s, acc=0, cnt=0, then compute the output.
- Output arithmetic:
  - Round half up: r = (sum + 2^(L-1)) >>> L, with L=log2(DECIM).
  - Apply the gain: g = r <<< GAIN_SHL.
  - Saturate g to the range [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - Any clip on I or Q sets sat_o. sat_o clears only on reset.
- Output register: I_BB/Q_BB are written and demod_iq_valid pulses for exactly one cycle. Outputs hold their value between pulses.
- Latency: the sample taken at edge k that completes a frame yields demod_iq_valid high in the cycle after edge k+2 (two-cycle registered latency). Full throughput: ADC_rdy_i may be high every cycle.
- sync_clr_i:
  - Clears phase, cnt, acc and rot_valid; I_BB, Q_BB and sat_o are unchanged.
  - Same cycle as ADC_rdy_i: clear wins and the sample is dropped.
  - A frame already in rot_valid is discarded, so no valid pulse is produced.
- Reset mid-frame: partial accumulation is lost and no output is produced for it.

Decomposition:
- Shared package iq_demod_pkg:
  - mode_t enum (MODE_BYP, MODE_POS, MODE_NEG).
  - Localparam helper for the log2 of DECIM.
  - A saturate function parametrised by input and output widths.
- One sub-module: iq_quarter_mixer. It implements stage 1: the phase counter, mode latch and registered rotation, and outputs rot_I, rot_Q and rot_valid.

Test Plan:
- Bypass, DECIM=4, constant I=3, Q=-2, ADC_rdy_i every 5th cycle -> first demod_iq_valid 2 cycles after the 4th strobe; I_BB=3, Q_BB=-2; sat_o=0.
- +fs/4 mode, input tone (10,0),(0,10),(-10,0),(0,-10) repeating, ADC_rdy_i every cycle -> every output is I_BB=10, Q_BB=0; demod_iq_valid every 4th cycle.
- Rounding, bypass, DECIM=4: I samples 1,1,1,0 -> I_BB=1; I samples -1,-1,0,0 -> I_BB=0; I samples -2,-2,-2,-1 -> I_BB=-2.
- GAIN_SHL=1, bypass, constant I=12, Q=-16 -> I_BB=15, Q_BB=-16; sat_o=1 and still 1 after a later frame with I=0.
- sync_clr_i asserted after 2 accepted samples, and again in the same cycle as an ADC_rdy_i -> no valid pulse from the partial frame; the next output is formed from exactly 4 post-clear samples.
- resetn low mid-frame, then mode_i change from bypass to -fs/4 mid-frame -> outputs zero during reset; the new mode applies only from the next frame start, with phase restarted at 0.
